// File: rtl/mac_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : mac_feeder
//  Description : Operand sequencer and result collector for a signed 8-bit
//                DSP MAC. Computes C = A(MxK) x B(KxN) one element at a time:
//                streams each dot product from two 1-cycle-latency operand
//                RAMs into the MAC, waits for its accumulated result, writes
//                it to the C RAM and clears the accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_feeder #(
    parameter int DIM_MAX = 16,
    parameter int DW      = $clog2(DIM_MAX) + 1,
    parameter int AW      = $clog2(DIM_MAX * DIM_MAX),
    parameter int TIMEOUT = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [DW-1:0]        cfg_m_i,
    input  logic [DW-1:0]        cfg_n_i,
    input  logic [DW-1:0]        cfg_k_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [AW-1:0]        a_addr_o,
    input  logic signed [7:0]    a_data_i,
    output logic [AW-1:0]        b_addr_o,
    input  logic signed [7:0]    b_data_i,
    output logic                 dsp_en_o,
    output logic                 dsp_valid_o,
    output logic signed [7:0]    dsp_input_o,
    output logic signed [7:0]    dsp_weight_o,
    output logic                 acc_clr_o,
    input  logic signed [31:0]   dsp_output_i,
    input  logic                 dsp_valid_i,
    output logic                 c_we_o,
    output logic [AW-1:0]        c_addr_o,
    output logic [31:0]          c_data_o
);

    localparam int            c_TW      = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] c_ONE     = DW'(1);
    localparam logic [DW-1:0] c_DIM_MAX = DW'(DIM_MAX);
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_CHECK  = 3'd1;
    localparam logic [2:0] c_STREAM = 3'd2;
    localparam logic [2:0] c_WAIT   = 3'd3;
    localparam logic [2:0] c_WRITE  = 3'd4;
    localparam logic [2:0] c_CLEAR  = 3'd5;
    localparam logic [2:0] c_FIN    = 3'd6;

    logic [2:0]             r_state;
    logic [2:0]             w_next;
    logic [DW-1:0]          r_cfg_m, r_cfg_n, r_cfg_k;
    logic [DW-1:0]          r_i, r_j, r_k;
    // r_a_row tracks i*K, r_b_ptr tracks k*N+j, r_c_addr tracks i*N+j
    logic [AW-1:0]          r_a_row, r_b_ptr, r_c_addr;
    logic [c_TW-1:0]        r_wait_cnt;
    logic [31:0]            r_result;
    logic                   r_err;
    // Operand pipeline: address issued -> RAM data -> registered MAC operands
    logic                   r_iss, r_iss_last;
    logic                   r_pair_vld, r_pair_last;
    logic signed [7:0]      r_din, r_wgt;

    logic w_cfg_bad, w_issue, w_last_elem, w_timeout, w_j_wrap;

    assign w_cfg_bad   = (r_cfg_m == '0) || (r_cfg_m > c_DIM_MAX) ||
                         (r_cfg_n == '0) || (r_cfg_n > c_DIM_MAX) ||
                         (r_cfg_k == '0) || (r_cfg_k > c_DIM_MAX);
    // STREAM spends one extra cycle (k == K) letting the last pair register
    assign w_issue     = (r_state == c_STREAM) && (r_k < r_cfg_k);
    assign w_j_wrap    = (r_j == r_cfg_n - c_ONE);
    assign w_last_elem = (r_i == r_cfg_m - c_ONE) && w_j_wrap;
    assign w_timeout   = (r_wait_cnt == c_TO_LAST) && !dsp_valid_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= c_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (start_i) w_next = c_CHECK;
            c_CHECK:  w_next = w_cfg_bad ? c_FIN : c_STREAM;
            c_STREAM: if (r_k == r_cfg_k) w_next = c_WAIT;
            c_WAIT: begin
                if (dsp_valid_i)    w_next = c_WRITE;
                else if (w_timeout) w_next = c_CLEAR;
            end
            c_WRITE:  w_next = c_CLEAR;
            c_CLEAR:  w_next = (r_err || w_last_elem) ? c_FIN : c_STREAM;
            c_FIN:    w_next = c_IDLE;
            default:  w_next = c_IDLE;
        endcase
    end

    // Output decode; everything idles at 0 outside its owning state
    always_comb begin
        busy_o       = (r_state != c_IDLE) && (r_state != c_FIN);
        done_o       = (r_state == c_FIN);
        err_o        = r_err;
        a_addr_o     = w_issue ? (r_a_row + AW'(r_k)) : '0;
        b_addr_o     = w_issue ? r_b_ptr : '0;
        dsp_en_o     = r_pair_vld || (r_state == c_WAIT);
        dsp_valid_o  = r_pair_vld && r_pair_last;
        dsp_input_o  = r_din;
        dsp_weight_o = r_wgt;
        acc_clr_o    = (r_state == c_CLEAR);
        c_we_o       = (r_state == c_WRITE);
        c_addr_o     = (r_state == c_WRITE) ? r_c_addr : '0;
        c_data_o     = (r_state == c_WRITE) ? r_result : '0;
    end

    // Operand pipeline: RAM read data is registered straight onto the MAC inputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_iss       <= 1'b0;
            r_iss_last  <= 1'b0;
            r_pair_vld  <= 1'b0;
            r_pair_last <= 1'b0;
            r_din       <= '0;
            r_wgt       <= '0;
        end else begin
            r_iss       <= w_issue;
            r_iss_last  <= w_issue && (r_k == r_cfg_k - c_ONE);
            r_pair_vld  <= r_iss;
            r_pair_last <= r_iss_last;
            r_din       <= r_iss ? a_data_i : 8'sd0;
            r_wgt       <= r_iss ? b_data_i : 8'sd0;
        end
    end

    // Job configuration, loop indices, address trackers, result capture, error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cfg_m    <= '0;
            r_cfg_n    <= '0;
            r_cfg_k    <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_a_row    <= '0;
            r_b_ptr    <= '0;
            r_c_addr   <= '0;
            r_wait_cnt <= '0;
            r_result   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wait_cnt <= '0;
            case (r_state)
                c_IDLE: if (start_i) begin
                    r_cfg_m  <= cfg_m_i;
                    r_cfg_n  <= cfg_n_i;
                    r_cfg_k  <= cfg_k_i;
                    r_err    <= 1'b0;
                    r_i      <= '0;
                    r_j      <= '0;
                    r_k      <= '0;
                    r_a_row  <= '0;
                    r_b_ptr  <= '0;
                    r_c_addr <= '0;
                end
                c_CHECK: if (w_cfg_bad) r_err <= 1'b1;
                c_STREAM: if (w_issue) begin
                    r_k     <= r_k + c_ONE;
                    r_b_ptr <= r_b_ptr + AW'(r_cfg_n);
                end
                c_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (dsp_valid_i)    r_result <= dsp_output_i;
                    else if (w_timeout) r_err    <= 1'b1;
                end
                c_CLEAR: begin
                    r_k      <= '0;
                    r_c_addr <= r_c_addr + 1'b1;
                    if (w_j_wrap) begin
                        r_j     <= '0;
                        r_i     <= r_i + c_ONE;
                        r_a_row <= r_a_row + AW'(r_cfg_k);
                        r_b_ptr <= '0;
                    end else begin
                        r_j     <= r_j + c_ONE;
                        r_b_ptr <= AW'(r_j + c_ONE);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_feeder
//  Description : Directed self-checking bench for mac_feeder with operand RAM
//                models and a 4-stage accumulating MAC model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_feeder;

    localparam int DIM_MAX = 16;
    localparam int DW      = 5;
    localparam int AW      = 8;
    localparam int TIMEOUT = 64;
    localparam int MAC_LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, start;
    logic [DW-1:0]        cfg_m, cfg_n, cfg_k;
    logic                 busy, done, err;
    logic [AW-1:0]        a_addr, b_addr, c_addr;
    logic signed [7:0]    a_data, b_data;
    logic                 dsp_en, dsp_valid, acc_clr, c_we;
    logic signed [7:0]    dsp_input, dsp_weight;
    logic signed [31:0]   dsp_output;
    logic                 dsp_valid_in;
    logic [31:0]          c_data;
    logic                 mac_mute;

    mac_feeder #(.DIM_MAX(DIM_MAX), .DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .cfg_m_i(cfg_m), .cfg_n_i(cfg_n), .cfg_k_i(cfg_k),
        .busy_o(busy), .done_o(done), .err_o(err),
        .a_addr_o(a_addr), .a_data_i(a_data),
        .b_addr_o(b_addr), .b_data_i(b_data),
        .dsp_en_o(dsp_en), .dsp_valid_o(dsp_valid),
        .dsp_input_o(dsp_input), .dsp_weight_o(dsp_weight),
        .acc_clr_o(acc_clr),
        .dsp_output_i(dsp_output), .dsp_valid_i(dsp_valid_in),
        .c_we_o(c_we), .c_addr_o(c_addr), .c_data_o(c_data)
    );

    // Operand RAMs with one cycle of read latency
    logic signed [7:0] a_mem [256];
    logic signed [7:0] b_mem [256];
    always @(posedge clk) begin
        a_data <= a_mem[a_addr];
        b_data <= b_mem[b_addr];
    end

    // MAC model: accumulate on enable, tag the last pair, deliver after MAC_LAT enabled cycles
    logic signed [31:0] mac_acc;
    logic [MAC_LAT-1:0] mac_pv;
    logic signed [31:0] mac_pd [MAC_LAT];
    always @(posedge clk) begin
        if (rst || acc_clr) begin
            mac_acc <= 0;
            mac_pv  <= '0;
            for (int s = 0; s < MAC_LAT; s++) mac_pd[s] <= 0;
        end else if (dsp_en) begin
            mac_acc   <= mac_acc + dsp_input * dsp_weight;
            mac_pv    <= {mac_pv[MAC_LAT-2:0], dsp_valid};
            mac_pd[0] <= mac_acc + dsp_input * dsp_weight;
            for (int s = 1; s < MAC_LAT; s++) mac_pd[s] <= mac_pd[s-1];
        end
    end
    assign dsp_valid_in = mac_pv[MAC_LAT-1] && !mac_mute;
    assign dsp_output   = mac_pd[MAC_LAT-1];

    // Event monitor, sampled mid-cycle
    int n_wr = 0, n_clr = 0, n_done = 0, n_en = 0;
    int wr_addr [1024];
    int wr_data [1024];
    always @(negedge clk) begin
        if (c_we && n_wr < 1024) begin
            wr_addr[n_wr] = int'(c_addr);
            wr_data[n_wr] = int'(c_data);
        end
        if (c_we)    n_wr++;
        if (acc_clr) n_clr++;
        if (done)    n_done++;
        if (dsp_en)  n_en++;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_job(input int m, input int n, input int k);
        @(negedge clk);
        cfg_m = DW'(m);
        cfg_n = DW'(n);
        cfg_k = DW'(k);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the number of negedges until done_o is seen
    task automatic wait_done(input string tag, input int budget, output int cyc);
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (done) begin
                cyc = c;
                return;
            end
        end
        check_val({tag, "_done_timeout"}, 64'(done), 64'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_ctl"}, {busy, done, err, dsp_en, dsp_valid, acc_clr, c_we}, 64'd0);
        check_val({tag, "_bus"}, {a_addr, b_addr, c_addr, dsp_input, dsp_weight}, 64'd0);
        check_val({tag, "_cdata"}, 64'(c_data), 64'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, w0, c0, d0, e0, bad_d, bad_a;
        rst = 1'b1; start = 1'b0; mac_mute = 1'b0;
        cfg_m = '0; cfg_n = '0; cfg_k = '0;
        for (int x = 0; x < 256; x++) begin a_mem[x] = 0; b_mem[x] = 0; end
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // 1x1x1: 3 * -4; also a start presented during the FIN cycle
        a_mem[0] = 8'sd3; b_mem[0] = -8'sd4;
        w0 = n_wr; c0 = n_clr; d0 = n_done;
        start_job(1, 1, 1);
        wait_done("t1", 200, cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("t1_fin_start_ignored", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        check_val("t1_writes", 64'(n_wr - w0), 64'd1);
        check_val("t1_addr", 64'(wr_addr[w0]), 64'd0);
        check_val("t1_data", 64'(wr_data[w0]), 64'(-12));
        check_val("t1_done_pulses", 64'(n_done - d0), 64'd1);
        check_val("t1_clr_pulses", 64'(n_clr - c0), 64'd1);
        check_val("t1_err", 64'(err), 64'd0);

        // 2x2x2: A=[1,2;3,4] B=[5,6;7,8] -> 19,22,43,50
        a_mem[0] = 1; a_mem[1] = 2; a_mem[2] = 3; a_mem[3] = 4;
        b_mem[0] = 5; b_mem[1] = 6; b_mem[2] = 7; b_mem[3] = 8;
        w0 = n_wr; c0 = n_clr; d0 = n_done;
        start_job(2, 2, 2);
        check_val("t2_busy_check", 64'(busy), 64'd1);
        @(negedge clk);
        @(negedge clk);
        check_val("t2_addr_k1", {a_addr, b_addr}, {8'd1, 8'd2});
        @(negedge clk);
        check_val("t2_pair0", {dsp_en, dsp_valid, dsp_input, dsp_weight}, {1'b1, 1'b0, 8'd1, 8'd5});
        @(negedge clk);
        check_val("t2_pair1", {dsp_en, dsp_valid, dsp_input, dsp_weight}, {1'b1, 1'b1, 8'd2, 8'd7});
        cfg_m = DW'(1); cfg_n = DW'(1); cfg_k = DW'(1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t2", 400, cyc);
        repeat (2) @(negedge clk);
        check_val("t2_writes", 64'(n_wr - w0), 64'd4);
        for (int e = 0; e < 4; e++) begin
            int exp_d [4] = '{19, 22, 43, 50};
            check_val($sformatf("t2_addr%0d", e), 64'(wr_addr[w0 + e]), 64'(e));
            check_val($sformatf("t2_data%0d", e), 64'(wr_data[w0 + e]), 64'(exp_d[e]));
        end
        check_val("t2_clr_pulses", 64'(n_clr - c0), 64'd4);
        check_val("t2_done_pulses", 64'(n_done - d0), 64'd1);

        // 16x16x16 of -128: every element 16 * 16384
        for (int x = 0; x < 256; x++) begin a_mem[x] = -8'sd128; b_mem[x] = -8'sd128; end
        w0 = n_wr;
        start_job(16, 16, 16);
        wait_done("t3", 20000, cyc);
        check_val("t3_err", 64'(err), 64'd0);
        repeat (2) @(negedge clk);
        check_val("t3_writes", 64'(n_wr - w0), 64'd256);
        bad_d = 0; bad_a = 0;
        for (int e = 0; e < 256; e++) begin
            if (wr_data[w0 + e] != 262144) bad_d++;
            if (wr_addr[w0 + e] != e) bad_a++;
        end
        check_val("t3_bad_data", 64'(bad_d), 64'd0);
        check_val("t3_bad_addr", 64'(bad_a), 64'd0);

        // K=0: error end two cycles after start, no MAC or memory activity
        w0 = n_wr; e0 = n_en; d0 = n_done;
        start_job(2, 2, 0);
        check_val("t4_busy", {busy, done}, {1'b1, 1'b0});
        @(negedge clk);
        check_val("t4_done_err", {done, err, busy}, {1'b1, 1'b1, 1'b0});
        repeat (3) @(negedge clk);
        check_val("t4_writes", 64'(n_wr - w0), 64'd0);
        check_val("t4_mac_en", 64'(n_en - e0), 64'd0);
        check_val("t4_done_pulses", 64'(n_done - d0), 64'd1);

        // MAC never answers: timeout after TIMEOUT WAIT cycles
        mac_mute = 1'b1;
        w0 = n_wr; c0 = n_clr; d0 = n_done;
        start_job(1, 1, 1);
        check_val("t5_err_cleared", 64'(err), 64'd0);
        wait_done("t5", 300, cyc);
        check_val("t5_cycles", 64'(cyc), 64'd68);
        check_val("t5_err", 64'(err), 64'd1);
        repeat (2) @(negedge clk);
        mac_mute = 1'b0;
        check_val("t5_writes", 64'(n_wr - w0), 64'd0);
        check_val("t5_clr_pulses", 64'(n_clr - c0), 64'd1);
        check_val("t5_done_pulses", 64'(n_done - d0), 64'd1);

        // Reset in the middle of STREAM aborts the job
        w0 = n_wr; d0 = n_done;
        start_job(2, 2, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("t6_rst");
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check_val("t6_writes", 64'(n_wr - w0), 64'd0);
        check_val("t6_done_pulses", 64'(n_done - d0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
